// File: rtl/ctrl_reg_arbiter.sv
// ctrl_reg_arbiter: shared 8-bit control register, round-robin write arbiter.
// Masters post masked writes. One write commits per clock.
//
// Ports:
//   clock   : single clock; all state updates on posedge
//   reset   : asynchronous, active-low clear
//   req     : per-master write request, one bit per master
//   lock    : per-master lock request, sampled with req
//   wr_mask : master i bit mask at [8i+7:8i]; a 1 selects the bit for writing
//   wr_data : master i write data at [8i+7:8i]
//   gnt     : one-hot registered ack; the master's write committed at the last edge
//   control : current register value
//   busy    : high while one master holds the lock
//   owner   : index of the most recent winner, zero-extended to 3 bits

module ctrl_reg_arbiter #(
  parameter int         NumRequesters = 4,
  parameter int         NumOutputs    = 8,
  parameter logic [7:0] PulseMask     = 8'h00,
  parameter logic [7:0] InitValue     = 8'h00
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NumRequesters-1:0]     req,
  input  logic [NumRequesters-1:0]     lock,
  input  logic [8*NumRequesters-1:0]   wr_mask,
  input  logic [8*NumRequesters-1:0]   wr_data,
  output logic [NumRequesters-1:0]     gnt,
  output logic [7:0]                   control,
  output logic                         busy,
  output logic [2:0]                   owner
);

  localparam logic [7:0] WidthMask =
    8'(9'h1FF >> (9 - NumOutputs));
  localparam logic [7:0] ResetValue =
    InitValue & ~PulseMask & WidthMask;
  localparam logic [2:0] LastIdx =
    3'(NumRequesters - 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t                   r_state;
  logic [NumRequesters-1:0] r_gnt;
  logic [7:0]               r_ctrl;
  logic                     r_busy;
  logic [2:0]               r_owner;

  logic                     w_found;
  logic [2:0]               w_win;
  logic                     w_win_lock;
  logic [7:0]               w_mask;
  logic [7:0]               w_data;
  logic [7:0]               w_next;
  logic [NumRequesters-1:0] w_onehot;
  int                       w_idx;

  // Winner search. In IDLE the loop walks from the farthest
  // slot back to owner+1 so the last hit is the nearest one.
  // In LOCKED only the current owner may write.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_owner;
    w_idx   = 0;
    if (r_state == ST_LOCKED) begin
      for (int i = 0; i < NumRequesters; i++) begin
        if (3'(i) == r_owner) begin
          w_found = req[i];
        end
      end
    end else begin
      for (int k = NumRequesters; k >= 1; k--) begin
        w_idx = (int'(r_owner) + k) % NumRequesters;
        for (int i = 0; i < NumRequesters; i++) begin
          if (i == w_idx && req[i]) begin
            w_found = 1'b1;
            w_win   = 3'(i);
          end
        end
      end
    end
  end

  // Winner's lock, mask and data. In LOCKED w_win is the owner,
  // so w_win_lock is also the lock-release test.
  always_comb begin
    w_win_lock = 1'b0;
    w_mask     = 8'h00;
    w_data     = 8'h00;
    w_onehot   = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (3'(i) == w_win) begin
        w_win_lock  = lock[i];
        w_mask      = wr_mask[8*i +: 8];
        w_data      = wr_data[8*i +: 8];
        w_onehot[i] = w_found;
      end
    end
  end

  // Pulse bits fall every edge unless the committed write
  // sets them again.
  always_comb begin
    w_next = r_ctrl & ~PulseMask;
    if (w_found) begin
      w_next = (w_next & ~(w_mask & WidthMask))
             | (w_data & w_mask & WidthMask);
    end
    w_next = w_next & WidthMask;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ctrl  <= ResetValue;
      r_busy  <= 1'b0;
      r_owner <= LastIdx;
    end else begin
      r_gnt  <= w_onehot;
      r_ctrl <= w_next;
      if (w_found) begin
        r_owner <= w_win;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_found && w_win_lock) begin
            r_state <= ST_LOCKED;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_win_lock) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign control = r_ctrl;
  assign busy    = r_busy;
  assign owner   = r_owner;

endmodule

// File: tb/tb_ctrl_reg_arbiter.sv
// tb_ctrl_reg_arbiter: directed vectors for ctrl_reg_arbiter.
// Three instances share stimulus: main, pulse-bit7, narrow.

module tb_ctrl_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wr_mask;
  logic [31:0] wr_data;

  logic [3:0]  gnt;
  logic [7:0]  ctrl;
  logic        busy;
  logic [2:0]  owner;

  logic [3:0]  p_gnt;
  logic [7:0]  p_ctrl;
  logic        p_busy;
  logic [2:0]  p_owner;

  logic [1:0]  n_gnt;
  logic [7:0]  n_ctrl;
  logic        n_busy;
  logic [2:0]  n_owner;

  ctrl_reg_arbiter #(
    .NumRequesters(4),
    .NumOutputs(8),
    .PulseMask(8'h01),
    .InitValue(8'hA5)
  ) u_dut (
    .clock(clk), .reset(rst_n),
    .req(req), .lock(lock),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .gnt(gnt), .control(ctrl),
    .busy(busy), .owner(owner)
  );

  ctrl_reg_arbiter #(
    .NumRequesters(4),
    .NumOutputs(8),
    .PulseMask(8'h80),
    .InitValue(8'h00)
  ) u_pls (
    .clock(clk), .reset(rst_n),
    .req(req), .lock(lock),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .gnt(p_gnt), .control(p_ctrl),
    .busy(p_busy), .owner(p_owner)
  );

  ctrl_reg_arbiter #(
    .NumRequesters(2),
    .NumOutputs(4),
    .PulseMask(8'h00),
    .InitValue(8'h00)
  ) u_nar (
    .clock(clk), .reset(rst_n),
    .req(req[1:0]), .lock(lock[1:0]),
    .wr_mask(wr_mask[15:0]),
    .wr_data(wr_data[15:0]),
    .gnt(n_gnt), .control(n_ctrl),
    .busy(n_busy), .owner(n_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  l;
    logic [31:0] m;
    logic [31:0] d;
    logic [3:0]  g;
    logic [7:0]  c;
    logic        b;
    logic [2:0]  o;
  } vec_t;

  vec_t vt[$];

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] LM = 32'hFF00_0FFF;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0]  r,
                       input logic [3:0]  l,
                       input logic [31:0] m,
                       input logic [31:0] d);
    req     = r;
    lock    = l;
    wr_mask = m;
    wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(
    input logic [3:0]  r,
    input logic [3:0]  l,
    input logic [31:0] m,
    input logic [31:0] d,
    input logic [3:0]  g,
    input logic [7:0]  c,
    input logic        b,
    input logic [2:0]  o);
    vec_t v;
    v = '{r, l, m, d, g, c, b, o};
    vt.push_back(v);
  endfunction

  initial begin
    drive(4'h0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;

    // round-robin, all four requesting
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h1, 8'hA4, 1'b0, 3'd0);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h2, 8'hA4, 1'b0, 3'd1);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h4, 8'hA4, 1'b0, 3'd2);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h8, 8'hA4, 1'b0, 3'd3);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h1, 8'hA4, 1'b0, 3'd0);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h2, 8'hA4, 1'b0, 3'd1);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h4, 8'hA4, 1'b0, 3'd2);
    add(4'hF, 4'h0, 32'h0, 32'h0, 4'h8, 8'hA4, 1'b0, 3'd3);
    // masked writes; bit0 is a pulse bit
    add(4'h1, 4'h0, 32'h0000_00FF, 32'h0000_00F0,
        4'h1, 8'hF0, 1'b0, 3'd0);
    add(4'h4, 4'h0, 32'h000F_0000, 32'h0005_0000,
        4'h4, 8'hF5, 1'b0, 3'd2);
    add(4'h4, 4'h0, 32'h000F_0000, 32'h0005_0000,
        4'h4, 8'hF5, 1'b0, 3'd2);
    add(4'h0, 4'h0, 32'h0, 32'h0,
        4'h0, 8'hF4, 1'b0, 3'd2);
    // lock: acquire, 3 locked writes, release write
    add(4'h2, 4'h2, 32'h0000_0F00, 32'h0000_0100,
        4'h2, 8'hF1, 1'b1, 3'd1);
    add(4'hB, 4'h2, LM, 32'h0000_0200,
        4'h2, 8'hF2, 1'b1, 3'd1);
    add(4'hB, 4'h2, LM, 32'h0000_0300,
        4'h2, 8'hF3, 1'b1, 3'd1);
    add(4'hB, 4'h2, LM, 32'h0000_0400,
        4'h2, 8'hF4, 1'b1, 3'd1);
    add(4'hB, 4'h0, LM, 32'h0000_0600,
        4'h2, 8'hF6, 1'b0, 3'd1);
    add(4'h9, 4'h0, LM, 32'h0,
        4'h8, 8'h00, 1'b0, 3'd3);
    add(4'h9, 4'h0, LM, 32'h0,
        4'h1, 8'h00, 1'b0, 3'd0);
    add(4'h8, 4'h0, LM, 32'h0,
        4'h8, 8'h00, 1'b0, 3'd3);
    // lock dropped with req low: no grant, exit
    add(4'h8, 4'h8, 32'h0, 32'h0,
        4'h8, 8'h00, 1'b1, 3'd3);
    add(4'h1, 4'h0, 32'h0, 32'h0,
        4'h0, 8'h00, 1'b0, 3'd3);
    add(4'h1, 4'h0, 32'h0000_00FF, 32'h0000_005A,
        4'h1, 8'h5A, 1'b0, 3'd0);
    add(4'h0, 4'h0, 32'h0, 32'h0,
        4'h0, 8'h5A, 1'b0, 3'd0);

    #12;
    chk("rst ctrl", 32'(ctrl), 32'hA4);
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst owner", 32'(owner), 32'd3);
    chk("rst p_ctrl", 32'(p_ctrl), 32'h00);
    chk("rst n_owner", 32'(n_owner), 32'd1);

    // edge while reset held low must not commit
    drive(4'hF, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    chk("rst hold ctrl", 32'(ctrl), 32'hA4);
    chk("rst hold gnt", 32'(gnt), 32'h0);
    chk("rst hold busy", 32'(busy), 32'h0);
    drive(4'h0, 4'h0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].l, vt[i].m, vt[i].d);
      tick();
      chk($sformatf("v%0d gnt", i),
          32'(gnt), 32'(vt[i].g));
      chk($sformatf("v%0d ctrl", i),
          32'(ctrl), 32'(vt[i].c));
      chk($sformatf("v%0d busy", i),
          32'(busy), 32'(vt[i].b));
      chk($sformatf("v%0d owner", i),
          32'(owner), 32'(vt[i].o));
    end

    // pulse bit7: single strobe, then back-to-back
    drive(4'h1, 4'h0, 32'h80, 32'h80);
    tick();
    chk("pls gnt", 32'(p_gnt), 32'h1);
    chk("pls hi1", 32'(p_ctrl), 32'hDA);
    drive(4'h0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("pls lo1", 32'(p_ctrl), 32'h5A);
    drive(4'h1, 4'h0, 32'h80, 32'h80);
    tick();
    chk("pls b2b a", 32'(p_ctrl), 32'hDA);
    tick();
    chk("pls b2b b", 32'(p_ctrl), 32'hDA);
    drive(4'h0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("pls lo2", 32'(p_ctrl), 32'h5A);
    drive(4'h1, 4'h0, 32'h80, 32'h00);
    tick();
    chk("pls wr0", 32'(p_ctrl), 32'h5A);

    // narrow instance: bits 7:4 stay 0
    drive(4'h1, 4'h0, 32'hFF, 32'hFF);
    tick();
    chk("nar ctrl", 32'(n_ctrl), 32'h0F);
    chk("nar owner", 32'(n_owner), 32'd0);
    chk("main ff", 32'(ctrl), 32'hFF);
    drive(4'h0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("main fe", 32'(ctrl), 32'hFE);

    // reset asserted mid-cycle while LOCKED
    drive(4'h8, 4'h8, 32'h0, 32'h0);
    tick();
    chk("lk6 gnt", 32'(gnt), 32'h8);
    chk("lk6 busy", 32'(busy), 32'h1);
    chk("lk6 owner", 32'(owner), 32'd3);
    drive(4'hD, 4'h8, 32'h0, 32'h0);
    tick();
    chk("lk6 gnt2", 32'(gnt), 32'h8);
    chk("lk6 busy2", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async busy", 32'(busy), 32'h0);
    chk("async gnt", 32'(gnt), 32'h0);
    chk("async owner", 32'(owner), 32'd3);
    chk("async ctrl", 32'(ctrl), 32'hA4);
    chk("async p_ctrl", 32'(p_ctrl), 32'h00);
    drive(4'h5, 4'h0, 32'h0, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post gnt", 32'(gnt), 32'h1);
    chk("post owner", 32'(owner), 32'd0);
    chk("post busy", 32'(busy), 32'h0);
    tick();
    chk("post gnt2", 32'(gnt), 32'h4);
    chk("post owner2", 32'(owner), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
